// File: rtl/weight_preload_receiver.sv
// Double-buffered weight tile receiver: rows stream into a shadow bank, and an
// activate swaps a completed shadow tile into the active bank feeding the array.
module weight_preload_receiver #(
  parameter int MATRIX_WIDTH = 14,
  parameter int BYTE_WIDTH   = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       enable,
  input  logic                                       load_weight,
  input  logic [BYTE_WIDTH-1:0]                      weight_address,
  input  logic                                       weight_signed,
  input  logic [MATRIX_WIDTH*BYTE_WIDTH-1:0]         weight_data,
  input  logic                                       activate_weight,
  output logic [MATRIX_WIDTH*MATRIX_WIDTH*BYTE_WIDTH-1:0] active_weights,
  output logic                                       active_signed,
  output logic                                       active_valid,
  output logic                                       shadow_full,
  output logic [BYTE_WIDTH-1:0]                      rows_loaded,
  output logic [2:0]                                 error
);

  localparam int ROW_W  = MATRIX_WIDTH * BYTE_WIDTH;
  localparam int TILE_W = ROW_W * MATRIX_WIDTH;
  localparam int ADDR_W = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;
  localparam logic [BYTE_WIDTH-1:0] LAST_COUNT = BYTE_WIDTH'(MATRIX_WIDTH - 1);
  localparam logic [BYTE_WIDTH-1:0] ROW_LIMIT  = BYTE_WIDTH'(MATRIX_WIDTH);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;

  state_t                  state_reg;
  logic [ROW_W-1:0]        shadow_reg [MATRIX_WIDTH];
  logic [MATRIX_WIDTH-1:0] row_valid_reg;
  logic [BYTE_WIDTH-1:0]   rows_loaded_reg;
  logic                    shadow_signed_reg;
  logic                    active_signed_reg;
  logic                    active_valid_reg;
  logic [TILE_W-1:0]       active_reg;
  logic [2:0]              error_reg;

  logic [TILE_W-1:0]       shadow_flat;
  logic [ADDR_W-1:0]       addr_idx;
  logic                    addr_ok;
  logic                    act_go;
  logic                    load_go;
  logic                    new_row;
  logic                    sign_mismatch;
  logic [2:0]              error_next;

  assign addr_idx = weight_address[ADDR_W-1:0];
  assign addr_ok  = (weight_address < ROW_LIMIT);
  assign new_row  = ~row_valid_reg[addr_idx];
  assign act_go   = activate_weight && (state_reg == FULL);
  // In FULL a load is only accepted when the same cycle swaps the tile out.
  assign load_go  = load_weight && addr_ok && ((state_reg != FULL) || act_go);
  assign sign_mismatch = load_go && !act_go && (state_reg == FILLING) &&
                         (weight_signed != shadow_signed_reg);

  assign error_next[0] = load_weight && !addr_ok;
  assign error_next[1] = load_weight && addr_ok && (state_reg == FULL) && !act_go;
  assign error_next[2] = (activate_weight && !act_go) || sign_mismatch;

  for (genvar gi = 0; gi < MATRIX_WIDTH; gi++) begin : g_flat
    assign shadow_flat[gi*ROW_W +: ROW_W] = shadow_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (!rst && enable && load_go) begin
      shadow_reg[addr_idx] <= weight_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= EMPTY;
      row_valid_reg     <= '0;
      rows_loaded_reg   <= '0;
      shadow_signed_reg <= 1'b0;
      active_signed_reg <= 1'b0;
      active_valid_reg  <= 1'b0;
      active_reg        <= '0;
      error_reg         <= '0;
    end else if (enable) begin
      error_reg <= error_next;
      if (act_go) begin
        active_reg        <= shadow_flat;
        active_signed_reg <= shadow_signed_reg;
        active_valid_reg  <= 1'b1;
        // A same-cycle load starts the next tile in the freshly cleared shadow.
        if (load_go) begin
          row_valid_reg     <= MATRIX_WIDTH'(1) << addr_idx;
          rows_loaded_reg   <= BYTE_WIDTH'(1);
          shadow_signed_reg <= weight_signed;
          state_reg         <= (MATRIX_WIDTH == 1) ? FULL : FILLING;
        end else begin
          row_valid_reg   <= '0;
          rows_loaded_reg <= '0;
          state_reg       <= EMPTY;
        end
      end else if (load_go) begin
        row_valid_reg[addr_idx] <= 1'b1;
        if (state_reg == EMPTY) begin
          shadow_signed_reg <= weight_signed;
        end
        if (new_row) begin
          rows_loaded_reg <= rows_loaded_reg + 1'b1;
          state_reg       <= (rows_loaded_reg == LAST_COUNT) ? FULL : FILLING;
        end
      end
    end else begin
      error_reg <= '0;
    end
  end

  assign active_weights = active_reg;
  assign active_signed  = active_signed_reg;
  assign active_valid   = active_valid_reg;
  assign shadow_full    = (state_reg == FULL);
  assign rows_loaded    = rows_loaded_reg;
  assign error          = error_reg;

endmodule
